dff_rr_write_arbiter: RTL and testbench
=======================================

Name: dff_rr_write_arbiter

Overview:
Round-robin arbiter and sequencer for a shared WIDTH-bit D flip-flop register with complementary outputs q and qb. Up to NREQ requesters each present a data word and a request. The block grants one requester at a time, captures that requester's word into the register, and tracks which requester wrote last and how many writes have occurred. It sits between the requester logic and the flip-flop bank, which it owns outright.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data width of the shared register
IDW, 2, width of last_id (must equal ceil(log2(NREQ)))

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; asynchronous, active-low
req  input  NREQ  request per requester; bit i is requester i
d_in  input  NREQ*WIDTH  write data; slice [i*WIDTH +: WIDTH] belongs to requester i
gnt  output  NREQ  registered one-hot grant, high for exactly one cycle per write
q  output  WIDTH  shared register contents
qb  output  WIDTH  bitwise complement of q, at all times
busy  output  1  high while in GRANT
last_id  output  IDW  index of the most recently granted requester
wr_count  output  8  number of completed writes, wraps modulo 256

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state=IDLE, gnt=0, q=0, qb=all ones, busy=0, last_id=0, wr_count=0.
  - Internal pointer ptr=NREQ-1, so requester 0 has first priority after reset.
- FSM has two states, IDLE and GRANT.
- IDLE, at a rising edge with req != 0:
  - Select the first i with req[i]=1, searching ptr+1, ptr+2, ... modulo NREQ.
  - Set gnt to one-hot i, last_id=i, ptr=i, state=GRANT.
- IDLE with req == 0: remain in IDLE; gnt=0; nothing else changes.
- GRANT, at the next rising edge (unconditional):
  - q <= d_in slice of the granted index; qb <= ~that slice.
  - wr_count <= wr_count+1, wrapping 255 -> 0.
  - gnt <= 0, state <= IDLE.
- Latency:
  - req sampled at edge E0 -> gnt high during E0..E1 -> q valid after E1.
  - Maximum throughput is one write every 2 cycles.
- Requester handshake:
  - Hold req and d_in stable until gnt is seen high.
  - d_in must remain valid through the GRANT cycle.
  - Drop req at the edge that ends GRANT.
  - A req still high in the following IDLE cycle is treated as a new request.
- Commitment: a write is committed once GRANT is entered. Dropping req during GRANT does not cancel it; q still loads d_in of the granted index.
- Requests arriving during GRANT are ignored until the next IDLE evaluation; they are not lost while held.
- Fairness: with all requests continuously asserted, grants go 0,1,2,...,NREQ-1,0,... Any single requester waits at most 2*NREQ cycles.
- Only one requester active: it is re-granted every 2 cycles regardless of ptr.
- Reset mid-GRANT: the write is aborted; q=0, wr_count=0, ptr=NREQ-1.
- Invariants:
  - gnt is zero or one-hot; never more than one bit set.
  - busy == (gnt != 0).
  - qb == ~q in every cycle, including during reset.

Test Plan:
1. Reset: hold rst_n=0 with random req/d_in -> gnt=0, q=8'h00, qb=8'hFF, wr_count=0, busy=0. Release rst_n -> no activity while req=0.
2. Single request: req=4'b0100, d_in slice2=8'hA5, sampled at E0 -> gnt=4'b0100 in the cycle after E0, last_id=2. After E1: q=8'hA5, qb=8'h5A, wr_count=1, gnt=0.
3. All requesting: req=4'b1111 held, slices i = 8'h10+i -> grants every 2 cycles in order 0,1,2,3,0. q sequence 10,11,12,13,10. wr_count reaches 5.
4. Pointer rotation: after requester 2 wins, assert req=4'b0101 -> requester 0 wins next (search 3,0). Then requester 2.
5. Reset mid-operation: pull rst_n low during GRANT for requester 1 (d=8'h3C) -> q stays 8'h00, wr_count=0. After release with req=4'b1010 -> requester 1 granted first.
6. Counter wrap: 256 single-requester writes -> wr_count steps 255 -> 0. Check q/qb complement on every write.

Source files
------------

// File: rtl/dff_rr_write_arbiter.sv
// Round-robin write arbiter that owns a shared WIDTH-bit flip-flop bank (q/qb).
// One requester is granted per two-cycle IDLE -> GRANT sequence, and its word is captured on GRANT exit.
module dff_rr_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   d_in,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic [WIDTH-1:0]        qb,
    output logic                    busy,
    output logic [IDW-1:0]          last_id,
    output logic [7:0]              wr_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic [IDW-1:0]    ptr;
    logic              sel_valid;
    logic [IDW-1:0]    sel_idx;
    logic [NREQ-1:0]   sel_onehot;
    logic [WIDTH-1:0]  wdata;

    // Search starts one past the last winner, so the last winner has the lowest priority.
    always_comb begin
        // NOTE: every variable gets a default before the loops, so no path leaves it unassigned (no latch).
        sel_valid  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!sel_valid && req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
                    sel_valid     = 1'b1;
                    sel_idx       = IDW'(i);
                    sel_onehot[i] = 1'b1;
                end
            end
        end
    end

    // last_id holds the granted index throughout GRANT, so it selects the write slice.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i == int'(last_id)) begin
                wdata = d_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            q        <= '0;
            busy     <= 1'b0;
            last_id  <= '0;
            wr_count <= '0;
            ptr      <= IDW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    gnt <= '0;
                    if (sel_valid) begin
                        gnt     <= sel_onehot;
                        last_id <= sel_idx;
                        ptr     <= sel_idx;
                        busy    <= 1'b1;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    // The write is committed here, even if req has since dropped.
                    q        <= wdata;
                    wr_count <= wr_count + 8'd1;
                    gnt      <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // qb is derived from q by inversion, so the complement also holds during reset.
    assign qb = ~q;

endmodule

// File: tb/tb_dff_rr_write_arbiter.sv
// Self-checking bench for dff_rr_write_arbiter: table-driven write vectors with a scoreboard,
// plus sequences for reset, reset during GRANT, and wr_count wrap.
module tb_dff_rr_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] d_in;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      qb;
    logic                  busy;
    logic [IDW-1:0]        last_id;
    logic [7:0]            wr_count;

    dff_rr_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .d_in     (d_in),
        .gnt      (gnt),
        .q        (q),
        .qb       (qb),
        .busy     (busy),
        .last_id  (last_id),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]       req;
        logic [NREQ*WIDTH-1:0] d;
        int                    idx;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [7:0]       cnt;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    logic [7:0] model_cnt;
    vec_t       vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one request, expects the grant one edge later and the captured word one edge after that.
    task automatic run_write(input vec_t v, input string tag);
        exp_t             e;
        logic [WIDTH-1:0] exp_qb;
        req  = v.req;
        d_in = v.d;
        model_cnt = model_cnt + 8'd1;
        e.q   = v.d[v.idx*WIDTH +: WIDTH];
        e.cnt = model_cnt;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check({tag, " gnt"},     32'(gnt),     32'(1) << v.idx);
        check({tag, " last_id"}, 32'(last_id), 32'(v.idx));
        check({tag, " busy"},    32'(busy),    32'd1);
        @(posedge clk);
        @(negedge clk);
        e      = sb.pop_front();
        exp_qb = ~e.q;
        check({tag, " q"},        32'(q),        32'(e.q));
        check({tag, " qb"},       32'(qb),       32'(exp_qb));
        check({tag, " wr_count"}, 32'(wr_count), 32'(e.cnt));
        check({tag, " gnt_idle"}, 32'(gnt),      32'd0);
        check({tag, " busy_idle"},32'(busy),     32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{req: 4'b1111, d: 32'h13121110, idx: 0};
        vecs[1] = '{req: 4'b1111, d: 32'h13121110, idx: 1};
        vecs[2] = '{req: 4'b1111, d: 32'h13121110, idx: 2};
        vecs[3] = '{req: 4'b1111, d: 32'h13121110, idx: 3};
        vecs[4] = '{req: 4'b1111, d: 32'h13121110, idx: 0};
        vecs[5] = '{req: 4'b0100, d: 32'h00A50000, idx: 2};
        vecs[6] = '{req: 4'b0101, d: 32'h00B200B0, idx: 0};
        vecs[7] = '{req: 4'b0101, d: 32'h00D200D0, idx: 2};

        // Reset held with random requests: nothing may happen.
        model_cnt = 8'd0;
        rst_n = 1'b0;
        req   = NREQ'($urandom);
        d_in  = $urandom;
        repeat (3) begin
            @(negedge clk);
            check("rst gnt",      32'(gnt),      32'd0);
            check("rst q",        32'(q),        32'h00);
            check("rst qb",       32'(qb),       32'hFF);
            check("rst wr_count", 32'(wr_count), 32'd0);
            check("rst busy",     32'(busy),     32'd0);
            req  = NREQ'($urandom);
            d_in = $urandom;
        end
        req   = '0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle gnt",      32'(gnt),      32'd0);
        check("idle busy",     32'(busy),     32'd0);
        check("idle wr_count", 32'(wr_count), 32'd0);
        check("idle last_id",  32'(last_id),  32'd0);

        // Rotation with all requesting, then single request and pointer wrap-around.
        for (int i = 0; i < 8; i++) begin
            run_write(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while requester 1 is in GRANT: the write must be dropped.
        req  = 4'b0010;
        d_in = 32'h00003C00;
        @(posedge clk);
        @(negedge clk);
        check("abort gnt", 32'(gnt), 32'b0010);
        rst_n = 1'b0;
        #1;
        check("abort q",        32'(q),        32'h00);
        check("abort qb",       32'(qb),       32'hFF);
        check("abort wr_count", 32'(wr_count), 32'd0);
        check("abort gnt_rst",  32'(gnt),      32'd0);
        @(posedge clk);
        @(negedge clk);
        check("abort q_hold", 32'(q), 32'h00);
        model_cnt = 8'd0;
        sb.delete();
        req  = 4'b1010;
        d_in = 32'h00007700;
        rst_n = 1'b1;
        run_write('{req: 4'b1010, d: 32'h00007700, idx: 1}, "post_rst");
        run_write('{req: 4'b1010, d: 32'h66007700, idx: 3}, "post_rst2");

        // 256 single-requester writes carry wr_count through 255 -> 0.
        for (int n = 0; n < 256; n++) begin
            vec_t v;
            v.req = 4'b1000;
            v.d   = $urandom;
            v.idx = 3;
            run_write(v, $sformatf("wrap%0d", n));
        end

        req = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
